// File: rtl/box_blast_ctrl.sv
// box_blast_ctrl
//   Applies one bomb explosion at a time to the destructible box field.
//   An accepted request scans the box table one entry per cycle and tests
//   each live box against the blast cross. Boxes that are hit play a
//   frame-timed destroy animation and are then retired. Completion is
//   signalled by a one-cycle exp_ack, which carries the number of boxes
//   destroyed on score_inc.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   exp_req      explosion request, held until exp_ack
//   exp_x/exp_y  explosion tile top-left, latched on acceptance
//   box_idx      table index being scanned
//   box_x/box_y  position of entry box_idx (same-cycle lookup)
//   frame_tick   one-cycle pulse per video frame
//   exp_ack      one-cycle completion pulse
//   busy         high from acceptance through the exp_ack cycle
//   box_alive    per-box existence, including while dying
//   box_dying    per-box destroy-animation flag
//   anim_frame   current destroy-animation frame
//   score_inc    boxes destroyed, valid only with exp_ack
module box_blast_ctrl #(
  parameter int unsigned NUM_BOXES  = 2,
  parameter int unsigned TILE       = 16,
  parameter int unsigned BLAST_LEN  = 1,
  parameter int unsigned DIE_FRAMES = 4,
  parameter int unsigned IDXW       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exp_req,
  input  logic [9:0]           exp_x,
  input  logic [9:0]           exp_y,
  output logic [IDXW-1:0]      box_idx,
  input  logic [9:0]           box_x,
  input  logic [9:0]           box_y,
  input  logic                 frame_tick,
  output logic                 exp_ack,
  output logic                 busy,
  output logic [NUM_BOXES-1:0] box_alive,
  output logic [NUM_BOXES-1:0] box_dying,
  output logic [1:0]           anim_frame,
  output logic [3:0]           score_inc
);

  localparam logic [10:0]     REACH      = 11'(BLAST_LEN * TILE);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_BOXES - 1);
  localparam logic [1:0]      LAST_FRAME = 2'(DIE_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_ANIM,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [10:0]            r_ex;
  logic [10:0]            r_ey;
  logic [NUM_BOXES-1:0]   r_mask;
  logic [3:0]             r_cnt;
  logic [IDXW-1:0]        r_idx;
  logic                   r_ack;
  logic                   r_busy;
  logic [NUM_BOXES-1:0]   r_alive;
  logic [NUM_BOXES-1:0]   r_dying;
  logic [1:0]             r_frame;
  logic [3:0]             r_score;

  logic [10:0]            w_bx;
  logic [10:0]            w_by;
  logic [10:0]            w_dx;
  logic [10:0]            w_dy;
  logic                   w_cross;
  logic [NUM_BOXES-1:0]   w_sel;
  logic [NUM_BOXES-1:0]   w_hit_vec;
  logic                   w_hit;
  logic [NUM_BOXES-1:0]   w_mask_next;
  logic [3:0]             w_cnt_next;

  assign box_idx    = r_idx;
  assign exp_ack    = r_ack;
  assign busy       = r_busy;
  assign box_alive  = r_alive;
  assign box_dying  = r_dying;
  assign anim_frame = r_frame;
  assign score_inc  = r_score;

  // Blast-cross test on the entry currently presented by the table.
  // Distances are max - min in 11 bits so they never wrap.
  always_comb begin
    w_bx    = {1'b0, box_x};
    w_by    = {1'b0, box_y};
    w_dx    = (w_bx >= r_ex) ? (w_bx - r_ex) : (r_ex - w_bx);
    w_dy    = (w_by >= r_ey) ? (w_by - r_ey) : (r_ey - w_by);
    w_cross = ((w_by == r_ey) && (w_dx <= REACH)) ||
              ((w_bx == r_ex) && (w_dy <= REACH));
    w_sel   = '0;
    for (int unsigned i = 0; i < NUM_BOXES; i++) begin
      w_sel[i] = (r_idx == IDXW'(i));
    end
    w_hit_vec   = w_cross ? (w_sel & r_alive & ~r_dying) : '0;
    w_hit       = |w_hit_vec;
    // The last entry's hit must be folded in on the same cycle the scan ends.
    w_mask_next = r_mask | w_hit_vec;
    w_cnt_next  = r_cnt + 4'(w_hit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ex    <= '0;
      r_ey    <= '0;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_alive <= '1;
      r_dying <= '0;
      r_frame <= '0;
      r_score <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (exp_req) begin
            r_ex    <= {1'b0, exp_x};
            r_ey    <= {1'b0, exp_y};
            r_mask  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end

        S_SCAN: begin
          r_mask <= w_mask_next;
          r_cnt  <= w_cnt_next;
          if (r_idx == LAST_IDX) begin
            if (w_cnt_next != '0) begin
              r_dying <= w_mask_next;
              r_frame <= '0;
              r_state <= S_ANIM;
            end else begin
              r_ack   <= 1'b1;
              r_score <= w_cnt_next;
              r_state <= S_DONE;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_ANIM: begin
          if (frame_tick) begin
            if (r_frame == LAST_FRAME) begin
              r_alive <= r_alive & ~r_dying;
              r_dying <= '0;
              r_frame <= '0;
              r_ack   <= 1'b1;
              r_score <= r_cnt;
              r_state <= S_DONE;
            end else begin
              r_frame <= r_frame + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_ack   <= 1'b0;
          r_score <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
